// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared AES definitions for the round datapath. Holds the
//               state geometry, the SubBytes engine state encoding, and the
//               forward and inverse FIPS-197 S-box tables side by side so
//               both directions come from a single source.
// Contents    : AES_STATE_W, AES_BYTES     - state geometry
//               aes_sb_state_e             - IDLE / RUN / DONE encoding
//               AES_SBOX_FWD, AES_SBOX_INV - 256-entry byte tables
//               aes_get_byte / aes_set_byte - byte access, byte 0 = MSB
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_sb_state_e;

  // Element 0 is the leftmost byte of the concatenation, so the table reads
  // row by row exactly as printed in FIPS-197 (row = high nibble).
  localparam logic [0:255][7:0] AES_SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] AES_SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Byte idx of an AES state; byte 0 occupies the most significant bits.
  function automatic logic [7:0] aes_get_byte(input logic [AES_STATE_W-1:0] s,
                                              input int idx);
    return s[AES_STATE_W-1-8*idx -: 8];
  endfunction

  // Returns s with byte idx replaced by b, same byte ordering as above.
  function automatic logic [AES_STATE_W-1:0] aes_set_byte(input logic [AES_STATE_W-1:0] s,
                                                          input int idx,
                                                          input logic [7:0] b);
    logic [AES_STATE_W-1:0] r;
    r = s;
    r[AES_STATE_W-1-8*idx -: 8] = b;
    return r;
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational forward AES S-box, a direct 256-entry lookup
//               with no internal pipelining.
// Ports       : i_byte  in   8  byte to substitute
//               o_byte  out  8  S(i_byte)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = AES_SBOX_FWD[i_byte];

endmodule : aes_sbox
`default_nettype wire

// File: rtl/aes_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_sub_bytes_seq
// Description : Sequential forward SubBytes engine. A 128-bit state is
//               accepted on start while ready, then BYTES_PER_CYCLE bytes
//               per cycle are pushed through a small bank of shared S-boxes.
//               The finished state is published on state_out together with a
//               one-cycle done pulse and held until the next completion.
// Parameters  : BYTES_PER_CYCLE  1, 2, 4, 8 or 16 bytes substituted per cycle
// Ports       : clk        in   1    rising-edge clock
//               rst        in   1    synchronous active-high reset
//               start      in   1    request, sampled only while ready
//               state_in   in   128  input state, byte 0 = MSB
//               ready      out  1    a start will be accepted this cycle
//               busy       out  1    substitution in progress
//               done       out  1    one-cycle completion pulse
//               state_out  out  128  last substituted state
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  localparam int NUM_STEPS = AES_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  generate
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
      $error("aes_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  aes_sb_state_e                       state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [AES_STATE_W-1:0]              work_q, work_d;
  logic [AES_STATE_W-1:0]              state_out_q, state_out_d;

  logic [BYTES_PER_CYCLE-1:0][7:0]     w_sbox_in;
  logic [BYTES_PER_CYCLE-1:0][7:0]     w_sbox_out;
  int                                  w_base;
  logic                                w_last_step;

  // Index of the first byte handled in the current RUN step.
  assign w_base      = 32'(cnt_q) * BYTES_PER_CYCLE;
  assign w_last_step = (cnt_q == LAST_STEP);

  // Gather the slice of the working register that goes through the S-boxes
  // this cycle; outside RUN the S-boxes see don't-care data that is unused.
  always_comb begin
    w_sbox_in = '0;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      w_sbox_in[j] = aes_get_byte(work_q, w_base + j);
    end
  end

  generate
    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
      aes_sbox u_sbox (
        .i_byte (w_sbox_in[g]),
        .o_byte (w_sbox_out[g])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register (together with the datapath flops it sequences)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      state_out_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      state_out_q <= state_out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    state_out_d = state_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = state_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          work_d = aes_set_byte(work_d, w_base + j, w_sbox_out[j]);
        end
        // The last step publishes the fully substituted state directly, so
        // state_out is valid in the same cycle done rises. The counter is
        // left at its final value rather than wrapping.
        if (w_last_step) begin
          state_out_d = work_d;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Accepting here gives back-to-back throughput of NUM_STEPS+1.
        if (start) begin
          work_d  = state_in;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from the current state
  // --------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
      end
      DONE: begin
        done  = 1'b1;
        ready = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign state_out = state_out_q;

endmodule : aes_sub_bytes_seq
`default_nettype wire
